// File: rtl/key_display_ctrl.sv
// key_display_ctrl
//   Debounces key presses reported by the keypad scanner, keeps a two-digit
//   history (newest key on the right digit, previous key on the left) and
//   time-multiplexes both digits onto one active-low seven-segment bus.
//
// Ports
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   key_d        hex code of the key reported by the scanner
//   key_held     high while the scanner reports a key held
//   key_accept   one-cycle pulse on the edge a press is committed
//   digit_new_q  most recently accepted key
//   digit_old_q  previously accepted key
//   seg_q        {g,f,e,d,c,b,a}, active-low
//   an_q         active-low anodes, [0] = new digit, [1] = old digit
//
// Optional build macro: KEY_DISPLAY_BLANK_EN
//   Adds a valid bit per digit; a digit never written shows blank.
//
// state        | meaning
// -------------+----------------------------------------------------
// ST_IDLE      | no key held, waiting for key_held
// ST_PRESS_WAIT| counting consecutive held samples of the same code
// ST_HELD      | press committed, key_d changes ignored
// ST_RELEASE_WAIT | counting consecutive released samples

module key_display_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REFRESH_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] key_d,
  input  logic       key_held,
  output logic       key_accept,
  output logic [3:0] digit_new_q,
  output logic [3:0] digit_old_q,
  output logic [6:0] seg_q,
  output logic [1:0] an_q
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] DB_ONE  = CW'(1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_ONE   = RW'(1);
  localparam logic [RW-1:0] R_LAST  = RW'(REFRESH_CYCLES - 1);
`ifdef KEY_DISPLAY_BLANK_EN
  localparam logic [6:0] SEG_RST = 7'b1111111;
`else
  localparam logic [6:0] SEG_RST = 7'b1000000;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_cand;
  logic [RW-1:0]   r_rcnt;
  logic            r_sel;
  logic            w_commit;
  logic [6:0]      w_seg_next;
`ifdef KEY_DISPLAY_BLANK_EN
  logic            r_valid_new;
  logic            r_valid_old;
`endif

  function automatic logic [6:0] f_hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // In PRESS_WAIT the commit only fires when key_d==r_cand, so key_d is
  // the committed code in both the normal and the single-sample case.
  always_comb begin
    w_commit = 1'b0;
    if (key_held) begin
      if (r_state == ST_IDLE && DEBOUNCE_CYCLES == 1)
        w_commit = 1'b1;
      else if (r_state == ST_PRESS_WAIT && key_d == r_cand && r_cnt == DB_LAST)
        w_commit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (key_held) begin
            r_cand <= key_d;
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_PRESS_WAIT;
              r_cnt   <= DB_ONE;
            end
          end
        end
        ST_PRESS_WAIT: begin
          if (!key_held) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (key_d != r_cand) begin
            r_cand <= key_d;
            r_cnt  <= DB_ONE;
          end else if (w_commit) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + DB_ONE;
          end
        end
        ST_HELD: begin
          if (!key_held) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_RELEASE_WAIT;
              r_cnt   <= DB_ONE;
            end
          end
        end
        ST_RELEASE_WAIT: begin
          if (key_held) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + DB_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_accept  <= 1'b0;
      digit_new_q <= '0;
      digit_old_q <= '0;
`ifdef KEY_DISPLAY_BLANK_EN
      r_valid_new <= 1'b0;
      r_valid_old <= 1'b0;
`endif
    end else begin
      key_accept <= w_commit;
      if (w_commit) begin
        digit_old_q <= digit_new_q;
        digit_new_q <= key_d;
`ifdef KEY_DISPLAY_BLANK_EN
        r_valid_old <= r_valid_new;
        r_valid_new <= 1'b1;
`endif
      end
    end
  end

  always_comb begin
    w_seg_next = r_sel ? f_hex7(digit_old_q) : f_hex7(digit_new_q);
`ifdef KEY_DISPLAY_BLANK_EN
    if (r_sel ? !r_valid_old : !r_valid_new)
      w_seg_next = 7'b1111111;
`endif
  end

  // Anode and segment bus are registered from the current select so both
  // switch together one cycle after r_sel changes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rcnt <= '0;
      r_sel  <= 1'b0;
      an_q   <= 2'b10;
      seg_q  <= SEG_RST;
    end else begin
      if (r_rcnt == R_LAST) begin
        r_rcnt <= '0;
        r_sel  <= ~r_sel;
      end else begin
        r_rcnt <= r_rcnt + R_ONE;
      end
      an_q  <= r_sel ? 2'b01 : 2'b10;
      seg_q <= w_seg_next;
    end
  end

endmodule

// File: tb/tb_key_display_ctrl.sv
module tb_key_display_ctrl;

  localparam int DEB = 4;
  localparam int REF = 8;
`ifdef KEY_DISPLAY_BLANK_EN
  localparam logic [6:0] SEG_RST = 7'b1111111;
`else
  localparam logic [6:0] SEG_RST = 7'b1000000;
`endif

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] key_d;
  logic       key_held;
  logic       key_accept;
  logic [3:0] digit_new_q;
  logic [3:0] digit_old_q;
  logic [6:0] seg_q;
  logic [1:0] an_q;

  key_display_ctrl #(.DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF)) u_dut (
    .clk(clk), .nrst(nrst), .key_d(key_d), .key_held(key_held),
    .key_accept(key_accept), .digit_new_q(digit_new_q),
    .digit_old_q(digit_old_q), .seg_q(seg_q), .an_q(an_q)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a press is accepted when, while released, the last DEB
  // samples were all held with one code; a release completes when, while
  // pressed, the last DEB samples were all released.
  logic [6:0] glyph [16];
  int         m_ncyc;
  bit         m_pressed;
  logic [3:0] m_new, m_old;
  int         m_accepts;
  bit         hq_h[$];
  logic [3:0] hq_d[$];
  int         n_acc;

  function automatic logic [6:0] m_seg(input bit sel);
`ifdef KEY_DISPLAY_BLANK_EN
    if (m_accepts < (sel ? 2 : 1)) return 7'b1111111;
`endif
    return sel ? glyph[m_old] : glyph[m_new];
  endfunction

  task automatic model_reset();
    m_ncyc = 0; m_pressed = 0; m_new = 0; m_old = 0; m_accepts = 0;
    hq_h.delete(); hq_d.delete();
  endtask

  task automatic step(input bit h, input logic [3:0] d);
    bit         sel;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    bit         exp_acc;
    bit         all_hi, all_lo;
    key_held = h;
    key_d    = d;
    @(posedge clk);
    sel     = ((m_ncyc / REF) % 2) == 1;
    exp_an  = sel ? 2'b01 : 2'b10;
    exp_seg = m_seg(sel);
    hq_h.push_back(h);
    hq_d.push_back(d);
    if (hq_h.size() > DEB) begin
      void'(hq_h.pop_front());
      void'(hq_d.pop_front());
    end
    exp_acc = 0;
    all_hi = (hq_h.size() == DEB);
    all_lo = (hq_h.size() == DEB);
    for (int i = 0; i < hq_h.size(); i++) begin
      if (!hq_h[i] || hq_d[i] != d) all_hi = 0;
      if (hq_h[i]) all_lo = 0;
    end
    if (!m_pressed && all_hi) begin
      exp_acc = 1; m_old = m_new; m_new = d; m_accepts++; m_pressed = 1;
    end else if (m_pressed && all_lo) begin
      m_pressed = 0;
    end
    m_ncyc++;
    #1;
    if (key_accept === 1'b1) n_acc++;
    chk("accept", key_accept, exp_acc);
    chk("digit_new", digit_new_q, m_new);
    chk("digit_old", digit_old_q, m_old);
    chk("an", an_q, exp_an);
    chk("seg", seg_q, exp_seg);
  endtask

  task automatic check_reset_values();
    chk("rst_accept", key_accept, 1'b0);
    chk("rst_new", digit_new_q, 4'h0);
    chk("rst_old", digit_old_q, 4'h0);
    chk("rst_an", an_q, 2'b10);
    chk("rst_seg", seg_q, SEG_RST);
  endtask

  task automatic release_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 4'h0);
  endtask

  initial begin
    bit         h;
    int         len;
    logic [3:0] d;
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    nrst = 1'b0; key_held = 1'b0; key_d = 4'h0;
    model_reset();
    #13;
    check_reset_values();
    @(negedge clk);
    nrst = 1'b1;

    // idle display cycling
    n_acc = 0;
    release_steps(40);
    chk("idle_acc_count", n_acc, 0);

    // first press of 5
    n_acc = 0;
    for (int i = 0; i < DEB; i++) step(1, 4'h5);
    chk("p5_acc_count", n_acc, 1);
    chk("p5_acc_last", key_accept, 1'b1);
    chk("p5_new", digit_new_q, 4'h5);

    // hold, release, press A
    n_acc = 0;
    step(1, 4'h5); step(1, 4'h5);
    release_steps(4);
    for (int i = 0; i < 6; i++) step(1, 4'hA);
    chk("pA_acc_count", n_acc, 1);
    chk("pA_new", digit_new_q, 4'hA);
    chk("pA_old", digit_old_q, 4'h5);
    release_steps(5);

    // press bounce then release bounce
    n_acc = 0;
    step(1, 4'h8); step(1, 4'h8); step(0, 4'h8);
    for (int i = 0; i < 4; i++) step(1, 4'h8);
    chk("b8_acc_count", n_acc, 1);
    step(0, 4'h8); step(0, 4'h8); step(1, 4'h8);
    for (int i = 0; i < 4; i++) step(0, 4'h8);
    chk("b8_rel_acc_count", n_acc, 1);

    // code change in PRESS_WAIT, then change while HELD
    n_acc = 0;
    step(1, 4'h1); step(1, 4'h1);
    for (int i = 0; i < 4; i++) step(1, 4'hF);
    for (int i = 0; i < 4; i++) step(1, 4'h3);
    chk("cF_acc_count", n_acc, 1);
    chk("cF_new", digit_new_q, 4'hF);
    chk("cF_old", digit_old_q, 4'h8);
    release_steps(5);

    // asynchronous reset in the middle of a press
    step(1, 4'h8); step(1, 4'h8);
    #2;
    nrst = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    n_acc = 0;
    for (int i = 0; i < DEB - 1; i++) step(1, 4'h8);
    chk("rst_fresh_none", n_acc, 0);
    step(1, 4'h8);
    chk("rst_fresh_one", n_acc, 1);
    release_steps(20);

    // randomized bursts
    for (int b = 0; b < 200; b++) begin
      h   = $urandom_range(0, 1);
      len = $urandom_range(1, 7);
      d   = 4'($urandom_range(0, 15));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) d = 4'($urandom_range(0, 15));
        step(h, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
